bram_bytewise: RTL and testbench

Parametrised byte-addressed block-RAM model. It is the successor to the fixed 32-bit, 801-word simulation RAM used by the MNIST datapath, and it serves as the weight/feature store for the layer engines.
- Adds true per-byte write enables, writes independent of read request, and configurable read latency.
- Adds a selectable read-during-write policy, an automatic zero-clear after reset, and out-of-range detection.

---
 rtl/bram_pkg.sv | 18 +
 rtl/bram_rd_pipe.sv | 37 +++
 rtl/bram_bytewise.sv | 100 ++++++++++
 tb/tb_bram_bytewise.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants for the byte-writable block RAM: read-during-write policy,
// controller state encoding and a constant log2 helper for sizing.
package bram_pkg;

  localparam logic RDW_OLD = 1'b0;
  localparam logic RDW_NEW = 1'b1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of {valid, data}. Stage 0 is the memory
// output register; data only advances with a valid so the output holds when idle.
module bram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  localparam int STAGES = RD_LAT - 1;

  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][DATA_W-1:0] dat_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      if (in_vld) dat_pipe[0] <= in_data;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_data = dat_pipe[STAGES];

endmodule

// File: rtl/bram_bytewise.sv
// Byte-addressed block RAM with per-byte write enables, configurable read
// latency, selectable read-during-write result and an optional post-reset clear.
module bram_bytewise
  import bram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 801,
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                R_req,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] W_req,
  input  logic [DATA_W-1:0]   W_data,
  output logic [DATA_W-1:0]   R_data,
  output logic                R_valid,
  output logic                busy,
  output logic                addr_err
);

  localparam int NB    = DATA_W / 8;
  localparam int BSH   = clog2(NB);
  localparam int IDX_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [IDX_W-1:0]  widx;
  logic              in_range, ready, clearing, wr_en, rd_en, err_d;
  logic [DATA_W-1:0] old_word, new_word, rd_word;

  assign idx      = addr >> BSH;
  assign widx     = idx[IDX_W-1:0];
  assign in_range = idx < ADDR_W'(DEPTH);

  // rst gates everything combinationally so a reset cycle never touches memory
  assign clearing = !rst && (state == ST_CLEAR);
  assign ready    = !rst && (state == ST_READY);
  assign busy     = rst || (state == ST_CLEAR);

  assign wr_en = ready && in_range && (W_req != '0);
  assign rd_en = ready && R_req;
  assign err_d = ready && !in_range && (R_req || (W_req != '0));

  always_comb begin
    old_word = in_range ? mem[widx] : '0;
    new_word = old_word;
    for (int b = 0; b < NB; b++)
      if (W_req[b]) new_word[8*b +: 8] = W_data[8*b +: 8];
    if (!in_range)
      rd_word = '0;
    else if (RDW_MODE == int'(RDW_NEW))
      rd_word = new_word;
    else
      rd_word = old_word;
  end

  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (W_req[b]) mem[widx][8*b +: 8] <= W_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + IDX_W'(1);
      if (clr_ptr == IDX_W'(DEPTH - 1)) state <= ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) addr_err <= 1'b0;
    else     addr_err <= err_d;
  end

  bram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_en),
    .in_data  (rd_word),
    .out_vld  (R_valid),
    .out_data (R_data)
  );

endmodule

// File: tb/tb_bram_bytewise.sv
// Bench for bram_bytewise: two instances (latency 1 / old-data, latency 3 /
// new-data) share stimulus; a queue-based model plus directed literal checks.
module tb_bram_bytewise;

  localparam int DEPTH = 801;

  logic        clk = 1'b0;
  logic        rst;
  logic        R_req;
  logic [31:0] addr;
  logic [3:0]  W_req;
  logic [31:0] W_data;
  logic [31:0] rd0, rd1;
  logic        rv0, rv1, bz0, bz1, ae0, ae1;

  always #5 clk = ~clk;

  bram_bytewise #(.RD_LAT(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .R_req(R_req), .addr(addr), .W_req(W_req),
    .W_data(W_data), .R_data(rd0), .R_valid(rv0), .busy(bz0), .addr_err(ae0));

  bram_bytewise #(.RD_LAT(3), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .R_req(R_req), .addr(addr), .W_req(W_req),
    .W_data(W_data), .R_data(rd1), .R_valid(rv1), .busy(bz1), .addr_err(ae1));

  int nvec = 0;
  int nmis = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [31:0] d; } rd_t;
  rd_t q0[$];
  rd_t q1[$];
  int  cyc = 0;
  int  clr_left = DEPTH;
  logic [31:0] mmem [DEPTH];
  logic [31:0] m_idx, m_old, m_new;
  logic        m_in;
  logic        ev0 = 0, ev1 = 0, eerr = 0;
  logic [31:0] ed0 = 0, ed1 = 0;

  always @(posedge clk) begin
    cyc++;
    eerr = 1'b0;
    if (rst) begin
      clr_left = DEPTH;
      q0.delete();
      q1.delete();
      ed0 = '0;
      ed1 = '0;
    end else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0)
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    end else begin
      m_idx = addr >> 2;
      m_in  = (m_idx < DEPTH);
      eerr  = !m_in && (R_req || (W_req != 0));
      m_old = m_in ? mmem[m_idx] : 32'h0;
      m_new = m_old;
      for (int b = 0; b < 4; b++)
        if (W_req[b]) m_new[8*b +: 8] = W_data[8*b +: 8];
      if (R_req) begin
        q0.push_back('{cyc,     m_in ? m_old : 32'h0});
        q1.push_back('{cyc + 2, m_in ? m_new : 32'h0});
      end
      if (m_in) mmem[m_idx] = m_new;
    end
    if (q0.size() > 0 && q0[0].due == cyc) begin
      ev0 = 1'b1; ed0 = q0[0].d; void'(q0.pop_front());
    end else ev0 = 1'b0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      ev1 = 1'b1; ed1 = q1[0].d; void'(q1.pop_front());
    end else ev1 = 1'b0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rvalid0", {31'b0, rv0}, {31'b0, ev0});
      chk("m_rdata0",  rd0, ed0);
      chk("m_rvalid1", {31'b0, rv1}, {31'b0, ev1});
      chk("m_rdata1",  rd1, ed1);
      chk("m_busy0",   {31'b0, bz0}, {31'b0, rst || (clr_left > 0)});
      chk("m_busy1",   {31'b0, bz1}, {31'b0, rst || (clr_left > 0)});
      chk("m_aerr0",   {31'b0, ae0}, {31'b0, eerr});
      chk("m_aerr1",   {31'b0, ae1}, {31'b0, eerr});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] d);
    R_req = r; addr = a; W_req = w; W_data = d;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] e0, input logic [31:0] e1);
    drive(1'b1, a, 4'h0, 32'h0);
    step();
    drive(1'b0, 32'h0, 4'h0, 32'h0);
    chk({nm, "_v0"}, {31'b0, rv0}, 32'd1);
    chk({nm, "_d0"}, rd0, e0);
    step();
    step();
    chk({nm, "_v1"}, {31'b0, rv1}, 32'd1);
    chk({nm, "_d1"}, rd1, e1);
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (bz0 && n < 2000) begin
      n++;
      step();
    end
    chk(nm, n, 32'd801);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_rvalid", {31'b0, rv0}, 32'd0);
    chk("rst_rdata",  rd0, 32'h0);
    chk("rst_busy",   {31'b0, bz0}, 32'd1);
    chk("rst_aerr",   {31'b0, ae1}, 32'd0);

    rst = 1'b0;
    #1;
    count_busy("clear_len");
    rd_chk("word800", 32'h0C80, 32'h0, 32'h0);

    // byte enables
    drive(1'b0, 32'h10, 4'hF, 32'hAABBCCDD); step();
    drive(1'b0, 32'h10, 4'h5, 32'h11223344); step();
    rd_chk("bytes", 32'h10, 32'hAA22CC44, 32'hAA22CC44);

    // back-to-back reads, words 0..3 hold 1..4
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'(k * 4), 4'hF, 32'(k + 1));
      step();
    end
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1'b1, 32'(k * 4), 4'h0, 32'h0);
      else       drive(1'b0, 32'h0, 4'h0, 32'h0);
      step();
      chk("b2b_v1", {31'b0, rv1}, {31'b0, (k >= 2 && k <= 5)});
      if (k >= 2 && k <= 5) chk("b2b_d1", rd1, 32'(k - 1));
      chk("b2b_v0", {31'b0, rv0}, {31'b0, (k <= 3)});
      if (k <= 3) chk("b2b_d0", rd0, 32'(k + 1));
    end

    // same-word read+write
    drive(1'b0, 32'h20, 4'hF, 32'h99); step();
    drive(1'b1, 32'h20, 4'hF, 32'h55); step();
    drive(1'b0, 32'h0, 4'h0, 32'h0);
    chk("rdw_v0", {31'b0, rv0}, 32'd1);
    chk("rdw_old", rd0, 32'h99);
    step(); step();
    chk("rdw_v1", {31'b0, rv1}, 32'd1);
    chk("rdw_new", rd1, 32'h55);
    rd_chk("rdw_after", 32'h20, 32'h55, 32'h55);

    // out of range
    drive(1'b0, 32'h0C84, 4'hF, 32'hFFFFFFFF); step();
    drive(1'b0, 32'h0, 4'h0, 32'h0);
    chk("oor_err", {31'b0, ae0}, 32'd1);
    step();
    chk("oor_err_end", {31'b0, ae0}, 32'd0);
    drive(1'b1, 32'h0C84, 4'h0, 32'h0); step();
    drive(1'b0, 32'h0, 4'h0, 32'h0);
    chk("oor_rd_v0", {31'b0, rv0}, 32'd1);
    chk("oor_rd_d0", rd0, 32'h0);
    chk("oor_rd_err", {31'b0, ae1}, 32'd1);
    step(); step();
    chk("oor_rd_v1", {31'b0, rv1}, 32'd1);
    chk("oor_rd_d1", rd1, 32'h0);
    rd_chk("oor_w800", 32'h0C80, 32'h0, 32'h0);
    rd_chk("oor_w0", 32'h0, 32'h1, 32'h1);

    // reset flushes an in-flight read, then reset again mid-clear
    drive(1'b1, 32'h4, 4'h0, 32'h0); step();
    drive(1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b1;
    step();
    chk("flush_v1a", {31'b0, rv1}, 32'd0);
    rst = 1'b0;
    step();
    chk("flush_v1b", {31'b0, rv1}, 32'd0);
    repeat (398) step();
    chk("midclr_busy", {31'b0, bz0}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 32'h0, 4'hF, 32'hDEADBEEF);
    #1;
    count_busy("reclear_len");
    drive(1'b0, 32'h0, 4'h0, 32'h0);
    rd_chk("post_clr0", 32'h0, 32'h0, 32'h0);
    rd_chk("post_clr10", 32'h10, 32'h0, 32'h0);

    repeat (4) step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
